bd_rr_arbiter: RTL
==================

BD_RR_ARBITER -- requirements
Module: bd_rr_arbiter

Interface
REQ-001 Parameter NUM_BITS, default 32: payload width per channel.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive words granted to one source (range 1..15).
REQ-003 clk  input  1  single clock; all state on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  4  per-source valid, bit i = source i.
REQ-006 in_data  input  4*NUM_BITS  per-source payload, source i at bits [i*NUM_BITS +: NUM_BITS].
REQ-007 in_ready  output  4  per-source ready, one-hot or zero.
REQ-008 out_valid  output  1  merged-channel valid, registered.
REQ-009 out_data  output  NUM_BITS (+2 with tag, REQ-030)  merged payload, registered.
REQ-010 out_ready  input  1  downstream ready.
REQ-011 grant_id  output  2  index of the source currently holding the grant, registered.

Function
REQ-012 Transfer on any channel SHALL occur only in a cycle where valid and ready are both 1 at posedge clk.
REQ-013 The output stage SHALL be one register slot; slot_free = !out_valid || out_ready.
REQ-014 in_ready[i] SHALL be 1 only when state is BURST, grant_id == i, and slot_free; all other bits 0.
REQ-015 On an input transfer, out_data SHALL load the granted payload and out_valid SHALL be 1 next cycle; latency input->output is exactly 1 cycle.
REQ-016 When out_valid && out_ready and no input transfer, out_valid SHALL clear next cycle.
REQ-017 out_valid/out_data SHALL hold stable while out_valid && !out_ready.
REQ-018 States: IDLE (no grant), BURST (grant held). IDLE->BURST when any in_valid is 1; BURST->IDLE when burst ends and no in_valid is 1.
REQ-019 Grant selection SHALL be round-robin: search starts at (last_grant+1) mod 4, first asserted in_valid wins; last_grant SHALL update on each new grant.
REQ-020 burst_cnt (4 bits) SHALL reset to 0 on each new grant and increment on each input transfer of the granted source.
REQ-021 Burst SHALL end when burst_cnt reaches MAX_BURST or the granted source drops in_valid while not stalled; on end, re-arbitration SHALL occur in the same cycle (no bubble if another source is valid).
REQ-022 A single requesting source SHALL be re-granted immediately after its burst ends (rotation search wraps to itself).
REQ-023 Grant SHALL NOT change while the output slot is stalled (out_valid && !out_ready) unless burst_cnt == MAX_BURST.
REQ-024 grant_id SHALL be meaningful only in BURST; it SHALL hold its last value in IDLE.
REQ-025 in_valid changes on non-granted sources SHALL have no effect until re-arbitration.

Reset
REQ-026 On reset low, immediately: state = IDLE, out_valid = 0, out_data = 0, in_ready = 0, grant_id = 0, burst_cnt = 0, last_grant = 3 (so source 0 wins first).
REQ-027 Reset asserted mid-burst SHALL discard the output slot content; no transfer SHALL complete in a cycle where reset is low.
REQ-028 After reset deasserts, the first arbitration SHALL occur at the first posedge with any in_valid = 1.

Configuration
REQ-029 Macro BD_ARB_TAG_EN selects source tagging.
REQ-030 With BD_ARB_TAG_EN defined: out_data width NUM_BITS+2, bits [NUM_BITS+1:NUM_BITS] = source index of that word, captured with the payload.
REQ-031 Without BD_ARB_TAG_EN: out_data width NUM_BITS, payload only; all other behaviour identical.

Verification
REQ-032 Reset then in_valid=4'b0001, data 0x11, out_ready=1 -> out_valid=1, out_data=0x11 one cycle after transfer; grant_id=0.
REQ-033 All four sources valid continuously, MAX_BURST=4, out_ready=1 -> output order 4 words src0, 4 src1, 4 src2, 4 src3, then src0; no idle cycles.
REQ-034 Only src2 valid for 10 words, MAX_BURST=4 -> 10 back-to-back outputs, grant_id stays 2, no bubble at burst boundaries.
REQ-035 out_ready held 0 for 5 cycles mid-burst -> out_data stable, in_ready=0, no word lost or duplicated once out_ready=1.
REQ-036 Reset pulsed low during src1 burst with out_valid=1 -> out_valid=0 immediately; after release src0 granted first if valid.
REQ-037 BD_ARB_TAG_EN defined, src3 sends 0xABCD0123 -> out_data = {2'b11, 0xABCD0123}.

Source files
------------

// File: rtl/bd_rr_arbiter.sv
// bd_rr_arbiter: 4-source round-robin arbiter with a per-grant burst limit feeding one registered output slot.
// Build option BD_ARB_TAG_EN: out_data gains a 2-bit source tag above the payload.
`default_nettype none

module bd_rr_arbiter #(
  parameter int NUM_BITS  = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            in_valid,
  input  logic [4*NUM_BITS-1:0] in_data,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
`ifdef BD_ARB_TAG_EN
  output logic [NUM_BITS+1:0]   out_data,
`else
  output logic [NUM_BITS-1:0]   out_data,
`endif
  input  logic                  out_ready,
  output logic [1:0]            grant_id
);

  localparam logic [0:0] IDLE       = 1'b0;
  localparam logic [0:0] BURST      = 1'b1;
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

  logic [0:0]          state;
  logic [1:0]          last_grant;
  logic [3:0]          burst_cnt;
  logic                slot_free;
  logic                any_valid;
  logic                xfer;
  logic                burst_full;
  logic                src_dropped;
  logic                rearb;
  logic [1:0]          next_grant;
  logic [NUM_BITS-1:0] grant_data;

  assign slot_free = !out_valid || out_ready;
  assign any_valid = |in_valid;

  always_comb begin
    in_ready = 4'b0000;
    if (state == BURST && slot_free) begin
      in_ready[grant_id] = 1'b1;
    end
  end

  assign xfer       = |(in_valid & in_ready);
  assign grant_data = in_data[int'(grant_id)*NUM_BITS +: NUM_BITS];

  // The burst closes on the edge of its last word, so the next grant is
  // already in place for the following cycle and no bubble appears.
  assign burst_full  = xfer && (burst_cnt + 4'd1 == BURST_LAST);
  assign src_dropped = (state == BURST) && !in_valid[grant_id] && slot_free;
  assign rearb       = burst_full || src_dropped;

  // Offsets 1..4 from last_grant; offset 4 wraps to the last grantee itself.
  // Scanning downward lets the nearest requester overwrite the farther ones.
  always_comb begin
    next_grant = last_grant;
    for (int k = 4; k >= 1; k--) begin
      if (in_valid[last_grant + 2'(k)]) begin
        next_grant = last_grant + 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
      burst_cnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state      <= BURST;
            grant_id   <= next_grant;
            last_grant <= next_grant;
            burst_cnt  <= 4'd0;
          end
        end
        default: begin
          if (rearb) begin
            burst_cnt <= 4'd0;
            if (any_valid) begin
              grant_id   <= next_grant;
              last_grant <= next_grant;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
`ifdef BD_ARB_TAG_EN
      out_data  <= {grant_id, grant_data};
`else
      out_data  <= grant_data;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
